// File: rtl/command_sequencer.sv
// Command sequencer: turns a finished accumulator burst into one execute command.
// Decodes r0, checks the operand count, then issues over a valid/ready handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   done                    accumulator busy-filling flag (high during a put burst)
//   r0_valid..r2_valid      slot-filled flags for the current burst
//   r0, r1, r2              opcode byte ([7:5] op, [3:0] dst), operand A, operand B
//   cmd_valid, cmd_ready    handshake to the execute stage
//   cmd_op, cmd_dst         decoded op and destination register
//   cmd_a, cmd_b            operands, zero when the op does not use them
//   busy, halted            status: not idle / HALT executed (sticky)
//   err_pulse, overrun      one-cycle reject pulse / burst lost while busy (sticky)
//   cmd_count, err_count    saturating accepted / rejected counters
module command_sequencer #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done,
    input  logic             r0_valid,
    input  logic             r1_valid,
    input  logic             r2_valid,
    input  logic [7:0]       r0,
    input  logic [7:0]       r1,
    input  logic [7:0]       r2,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [2:0]       cmd_op,
    output logic [3:0]       cmd_dst,
    output logic [7:0]       cmd_a,
    output logic [7:0]       cmd_b,
    output logic             busy,
    output logic             halted,
    output logic             err_pulse,
    output logic             overrun,
    output logic [CNT_W-1:0] cmd_count,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_ERROR,
        S_HALTED
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t     state;
    logic       done_d;
    logic [1:0] seen_cnt;
    logic [1:0] cnt_l;
    logic [7:0] r0_l;
    logic [7:0] r1_l;
    logic [7:0] r2_l;

    logic       eob;
    logic [1:0] vsum;
    logic [2:0] op_l;
    logic [1:0] req_cnt;
    logic       uses_a;
    logic       uses_b;

    assign eob  = done_d & ~done;
    assign vsum = {1'b0, r0_valid} + {1'b0, r1_valid} + {1'b0, r2_valid};
    assign op_l = r0_l[7:5];

    // Required operand count includes the opcode slot itself.
    always_comb begin
        req_cnt = 2'd3;
        uses_a  = 1'b1;
        uses_b  = 1'b1;
        unique case (op_l)
            OP_NOP, OP_HALT: begin
                req_cnt = 2'd1;
                uses_a  = 1'b0;
                uses_b  = 1'b0;
            end
            OP_LOAD, OP_SHL: begin
                req_cnt = 2'd2;
                uses_b  = 1'b0;
            end
            default: begin
                req_cnt = 2'd3;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            done_d    <= 1'b0;
            seen_cnt  <= '0;
            cnt_l     <= '0;
            r0_l      <= '0;
            r1_l      <= '0;
            r2_l      <= '0;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_dst   <= '0;
            cmd_a     <= '0;
            cmd_b     <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            err_pulse <= 1'b0;
            overrun   <= 1'b0;
            cmd_count <= '0;
            err_count <= '0;
        end else begin
            done_d    <= done;
            err_pulse <= 1'b0;

            // Slot counts only grow within a burst; every burst end clears.
            if (eob) begin
                seen_cnt <= '0;
            end else if (done && (vsum > seen_cnt)) begin
                seen_cnt <= vsum;
            end

            if (eob && (state != S_IDLE) && (state != S_HALTED)) begin
                overrun <= 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (eob) begin
                        r0_l  <= r0;
                        r1_l  <= r1;
                        r2_l  <= r2;
                        cnt_l <= seen_cnt;
                        busy  <= 1'b1;
                        if (seen_cnt == 2'd0) begin
                            state     <= S_ERROR;
                            err_pulse <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                        end else begin
                            state <= S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    if (cnt_l != req_cnt) begin
                        state     <= S_ERROR;
                        err_pulse <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                    end else if (op_l == OP_NOP) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (cmd_count != '1) begin
                            cmd_count <= cmd_count + CNT_W'(1);
                        end
                    end else if (op_l == OP_HALT) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end else begin
                        state     <= S_ISSUE;
                        cmd_valid <= 1'b1;
                        cmd_op    <= op_l;
                        cmd_dst   <= r0_l[3:0];
                        cmd_a     <= uses_a ? r1_l : 8'd0;
                        cmd_b     <= uses_b ? r2_l : 8'd0;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        cmd_valid <= 1'b0;
                        if (cmd_count != '1) begin
                            cmd_count <= cmd_count + CNT_W'(1);
                        end
                    end
                end
                S_ERROR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_command_sequencer.sv
// Directed bench for command_sequencer: opcode table plus stall, overrun,
// empty-burst, async reset, HALT and counter saturation sequences.
module tb_command_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done = 1'b0;
    logic        r0_valid = 1'b0;
    logic        r1_valid = 1'b0;
    logic        r2_valid = 1'b0;
    logic [7:0]  r0 = 8'd0;
    logic [7:0]  r1 = 8'd0;
    logic [7:0]  r2 = 8'd0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_dst;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        busy;
    logic        halted;
    logic        err_pulse;
    logic        overrun;
    logic [15:0] cmd_count;
    logic [7:0]  err_count;

    command_sequencer #(
        .CNT_W(16),
        .ERR_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .done      (done),
        .r0_valid  (r0_valid),
        .r1_valid  (r1_valid),
        .r2_valid  (r2_valid),
        .r0        (r0),
        .r1        (r1),
        .r2        (r2),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .busy      (busy),
        .halted    (halted),
        .err_pulse (err_pulse),
        .overrun   (overrun),
        .cmd_count (cmd_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_cmd = 0;
    int exp_err = 0;

    typedef struct {
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        int         nval;
        logic       valid;
        logic       acc;
        logic       err;
        logic [2:0] op;
        logic [3:0] dst;
        logic [7:0] a;
        logic [7:0] b;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the caller just after the negedge of the end-of-burst cycle T.
    task automatic burst(input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input int nval);
        @(negedge clk);
        done     = 1'b1;
        r0       = a0;
        r1       = a1;
        r2       = a2;
        r0_valid = (nval >= 1);
        r1_valid = (nval >= 2);
        r2_valid = (nval >= 3);
        @(negedge clk);
        r1_valid = 1'b0;
        r2_valid = 1'b0;
        @(negedge clk);
        done     = 1'b0;
        r0_valid = 1'b0;
    endtask

    initial begin
        vt[0]  = '{8'h45, 8'h0A, 8'h14, 3, 1'b1, 1'b1, 1'b0, 3'd2, 4'h5, 8'h0A, 8'h14};
        vt[1]  = '{8'h23, 8'h7F, 8'h99, 2, 1'b1, 1'b1, 1'b0, 3'd1, 4'h3, 8'h7F, 8'h00};
        vt[2]  = '{8'h45, 8'h0A, 8'h14, 2, 1'b0, 1'b0, 1'b1, 3'd0, 4'h0, 8'h00, 8'h00};
        vt[3]  = '{8'h00, 8'h11, 8'h22, 1, 1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 8'h00, 8'h00};
        vt[4]  = '{8'h6A, 8'h33, 8'h44, 3, 1'b1, 1'b1, 1'b0, 3'd3, 4'hA, 8'h33, 8'h44};
        vt[5]  = '{8'h81, 8'hF0, 8'h0F, 3, 1'b1, 1'b1, 1'b0, 3'd4, 4'h1, 8'hF0, 8'h0F};
        vt[6]  = '{8'hBF, 8'hAA, 8'h55, 3, 1'b1, 1'b1, 1'b0, 3'd5, 4'hF, 8'hAA, 8'h55};
        vt[7]  = '{8'hC4, 8'h01, 8'h02, 2, 1'b1, 1'b1, 1'b0, 3'd6, 4'h4, 8'h01, 8'h00};
        vt[8]  = '{8'hC4, 8'h01, 8'h02, 3, 1'b0, 1'b0, 1'b1, 3'd0, 4'h0, 8'h00, 8'h00};
        vt[9]  = '{8'h00, 8'h01, 8'h02, 2, 1'b0, 1'b0, 1'b1, 3'd0, 4'h0, 8'h00, 8'h00};
        vt[10] = '{8'h23, 8'h7F, 8'h00, 3, 1'b0, 1'b0, 1'b1, 3'd0, 4'h0, 8'h00, 8'h00};

        // Reset state
        #12;
        chk("rst cmd_valid", cmd_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst halted", halted, 0);
        chk("rst overrun", overrun, 0);
        chk("rst cmd_count", cmd_count, 0);
        chk("rst err_count", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmd_ready = 1'b1;

        // Opcode table, execute stage always ready
        for (int i = 0; i < 11; i++) begin
            burst(vt[i].r0, vt[i].r1, vt[i].r2, vt[i].nval);
            @(negedge clk);
            chk($sformatf("v%0d decode busy", i), busy, 1);
            @(negedge clk);
            chk($sformatf("v%0d cmd_valid", i), cmd_valid, vt[i].valid);
            chk($sformatf("v%0d err_pulse", i), err_pulse, vt[i].err);
            if (vt[i].valid) begin
                chk($sformatf("v%0d cmd_op", i), cmd_op, vt[i].op);
                chk($sformatf("v%0d cmd_dst", i), cmd_dst, vt[i].dst);
                chk($sformatf("v%0d cmd_a", i), cmd_a, vt[i].a);
                chk($sformatf("v%0d cmd_b", i), cmd_b, vt[i].b);
            end
            if (vt[i].acc) exp_cmd++;
            if (vt[i].err) exp_err++;
            @(negedge clk);
            chk($sformatf("v%0d idle busy", i), busy, 0);
            chk($sformatf("v%0d idle valid", i), cmd_valid, 0);
            chk($sformatf("v%0d cmd_count", i), cmd_count, exp_cmd);
            chk($sformatf("v%0d err_count", i), err_count, exp_err);
        end

        // LOAD stalled four cycles, accepted on the fifth
        cmd_ready = 1'b0;
        burst(8'h23, 8'h7F, 8'h00, 2);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall valid", cmd_valid, 1);
            chk("stall op", cmd_op, 1);
            chk("stall dst", cmd_dst, 3);
            chk("stall a", cmd_a, 8'h7F);
            chk("stall b", cmd_b, 0);
            chk("stall count", cmd_count, exp_cmd);
        end
        @(negedge clk);
        chk("stall valid 5th", cmd_valid, 1);
        cmd_ready = 1'b1;
        exp_cmd++;
        @(negedge clk);
        chk("stall done valid", cmd_valid, 0);
        chk("stall done count", cmd_count, exp_cmd);
        chk("no overrun yet", overrun, 0);

        // Second burst ends while the first command is stalled
        cmd_ready = 1'b0;
        burst(8'h45, 8'h01, 8'h02, 3);
        @(negedge clk);
        @(negedge clk);
        chk("ovr first valid", cmd_valid, 1);
        burst(8'h81, 8'h07, 8'h07, 3);
        @(negedge clk);
        chk("ovr sticky", overrun, 1);
        chk("ovr valid", cmd_valid, 1);
        chk("ovr op", cmd_op, 2);
        chk("ovr a", cmd_a, 8'h01);
        chk("ovr b", cmd_b, 8'h02);
        cmd_ready = 1'b1;
        exp_cmd++;
        @(negedge clk);
        chk("ovr accepted", cmd_count, exp_cmd);
        repeat (3) @(negedge clk);
        chk("ovr dropped valid", cmd_valid, 0);
        chk("ovr dropped busy", busy, 0);
        chk("ovr dropped count", cmd_count, exp_cmd);

        // Burst with no filled slots goes straight to ERROR
        burst(8'h45, 8'h01, 8'h02, 0);
        @(negedge clk);
        chk("empty err_pulse", err_pulse, 1);
        chk("empty busy", busy, 1);
        exp_err++;
        @(negedge clk);
        chk("empty pulse end", err_pulse, 0);
        chk("empty busy end", busy, 0);
        chk("empty err_count", err_count, exp_err);

        // Async reset in the middle of a stalled handshake
        cmd_ready = 1'b0;
        burst(8'h6A, 8'h03, 8'h04, 3);
        @(negedge clk);
        @(negedge clk);
        chk("arst pre valid", cmd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst valid", cmd_valid, 0);
        chk("arst busy", busy, 0);
        chk("arst op", cmd_op, 0);
        chk("arst overrun", overrun, 0);
        chk("arst cmd_count", cmd_count, 0);
        chk("arst err_count", err_count, 0);
        exp_cmd = 0;
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cmd_ready = 1'b1;

        // HALT parks the block until reset
        burst(8'hE0, 8'h00, 8'h00, 1);
        @(negedge clk);
        @(negedge clk);
        chk("halt halted", halted, 1);
        chk("halt busy", busy, 1);
        chk("halt valid", cmd_valid, 0);
        burst(8'h45, 8'h01, 8'h02, 3);
        repeat (4) @(negedge clk);
        chk("halt ignore valid", cmd_valid, 0);
        chk("halt ignore ovr", overrun, 0);
        chk("halt ignore err", err_count, 0);
        chk("halt still", halted, 1);
        rst_n = 1'b0;
        #1;
        chk("halt rst halted", halted, 0);
        chk("halt rst busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reject counter saturates at all-ones
        for (int i = 0; i < 260; i++) begin
            burst(8'h00, 8'h00, 8'h00, 0);
        end
        repeat (2) @(negedge clk);
        chk("err_count sat", err_count, 8'hFF);
        chk("sat busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
